uart_tx_piso: RTL and testbench

Serial transmitter for the board-level UART link. It accepts one parallel byte per handshake and shifts it out LSB-first on a single line, framed as 8N1 (start bit, 8 data bits, 1 stop bit). It sits between user logic (for example a counter or FSM producing bytes) and the FPGA TX pin. It is the sending counterpart of the capture-side flip-flop and shift-register blocks.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/baud_tick_gen.sv | 38 +++
 rtl/uart_tx_piso.sv | 127 ++++++++++++
 tb/tb_uart_tx_piso.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths: state encoding,
// baud divider arithmetic and counter sizing.
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t DATA  = 2'd2;
    localparam state_t STOP  = 2'd3;

    // Clock cycles per bit; integer truncation is intentional.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Width of a counter that spans 0..div-1 (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    localparam int unsigned DEF_DIV   = calc_div(100_000_000, 9600);
    localparam int unsigned DEF_CNT_W = cnt_width(DEF_DIV);

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: one-cycle tick every DIV clocks while clear is low.
// Holding clear restarts the bit period from zero.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV   = DEF_DIV,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_p,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = !clear && (cnt_q == LAST);

    // Count up, wrapping on each tick and restarting when cleared.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_piso.sv
// 8N1 UART transmitter: accepts a parallel word on a start/idle handshake and
// shifts it out LSB-first behind a start bit and ahead of a stop bit.
module uart_tx_piso
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_p,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W = cnt_width(DIV);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 clear;

    // Counter is parked at zero while idle so the start bit gets a full period
    // from the accept edge; every other state entry coincides with a wrap.
    assign clear = (state_q == IDLE);

    baud_tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_baud_tick_gen (
        .clk     (clk),
        .reset_p (reset_p),
        .clear   (clear),
        .tick    (tick)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and shift-register update.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d = tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // A request already pending at the stop tick is taken on this
                // edge, so the next start bit overlaps the tx_done pulse.
                if (tick) begin
                    if (tx_start) begin
                        shift_d = tx_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && tick;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Directed bench for uart_tx_piso with DIV = 10 (1000 Hz clock, 100 baud).
module tb_uart_tx_piso;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_piso #(
        .CLK_FREQ  (1000),
        .BAUD      (100),
        .DATA_BITS (8)
    ) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request a frame; returns sampled in cycle 0 of the frame.
    task automatic accept(input logic [7:0] data);
        tx_data  = data;
        tx_start = 1'b1;
        step();
        check("accept done", tx_done, 1'b0);
    endtask

    // Check ncyc cycles of a frame against pat ({stop, data, start}, bit 0 first).
    // mode 0: start low; 1: poke start with 8'hFF at cycle 30;
    // 2: scramble tx_data every cycle; 3: hold start high with nxt queued.
    task automatic frame(input string tag, input logic [9:0] pat, input int ncyc,
                         input int mode, input logic [7:0] nxt);
        for (int c = 0; c < ncyc; c++) begin
            check({tag, " tx"}, tx, pat[c / 10]);
            check({tag, " busy"}, busy, 1'b1);
            if (c > 0) check({tag, " done"}, tx_done, 1'b0);
            case (mode)
                1: begin
                    tx_start = (c == 30);
                    tx_data  = (c == 30) ? 8'hFF : 8'h00;
                end
                2: begin
                    tx_start = 1'b0;
                    tx_data  = 8'($urandom);
                end
                3: begin
                    tx_start = 1'b1;
                    tx_data  = nxt;
                end
                default: tx_start = 1'b0;
            endcase
            step();
        end
    endtask

    // Frame end with nothing queued: one-cycle tx_done, line idle.
    task automatic end_normal(input string tag);
        check({tag, " end done"}, tx_done, 1'b1);
        check({tag, " end busy"}, busy, 1'b0);
        check({tag, " end tx"}, tx, 1'b1);
        step();
        check({tag, " post done"}, tx_done, 1'b0);
        check({tag, " post busy"}, busy, 1'b0);
    endtask

    initial begin
        reset_p  = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", tx_done, 1'b0);
        reset_p = 1'b0;

        for (int i = 0; i < 50; i++) begin
            step();
            check("idle tx", tx, 1'b1);
            check("idle busy", busy, 1'b0);
            check("idle done", tx_done, 1'b0);
        end

        // 8'hA5: 0,1,0,1,0,0,1,0,1,1
        accept(8'hA5);
        frame("a5", 10'b1101001010, 100, 0, 8'h00);
        end_normal("a5");

        // 8'hC3 in flight, 8'hFF request mid-frame must be ignored.
        accept(8'hC3);
        frame("ign", 10'b1110000110, 100, 1, 8'h00);
        end_normal("ign");
        repeat (5) begin
            step();
            check("ign idle done", tx_done, 1'b0);
        end

        // Back-to-back 8'h00 then 8'h3C with start held high.
        accept(8'h00);
        frame("b2b0", 10'b1000000000, 100, 3, 8'h3C);
        check("b2b seam done", tx_done, 1'b1);
        check("b2b seam tx", tx, 1'b0);
        check("b2b seam busy", busy, 1'b1);
        frame("b2b1", 10'b1001111000, 100, 0, 8'h00);
        end_normal("b2b1");

        // Abort 45 cycles into an 8'h77 frame.
        accept(8'h77);
        frame("abort", 10'b1011101110, 45, 0, 8'h00);
        #1;
        reset_p = 1'b1;
        #1;
        check("abort tx", tx, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort done", tx_done, 1'b0);
        step();
        reset_p = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("abort idle done", tx_done, 1'b0);
            check("abort idle tx", tx, 1'b1);
        end
        accept(8'h01);
        frame("x01", 10'b1000000010, 100, 0, 8'h00);
        end_normal("x01");

        // 8'h5A with tx_data changing every cycle after accept.
        accept(8'h5A);
        frame("x5a", 10'b1010110100, 100, 2, 8'h00);
        end_normal("x5a");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
